// File: rtl/pmod_pkg.sv
// Shared encodings and frame geometry for the PMOD host.
package pmod_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_GAP  = 3'd4;

    localparam int LEN_SLOTS      = 5;
    localparam int ADDR_SLOTS     = 16;
    localparam int SLOTS_PER_BYTE = 4;
    localparam int SLOT_W         = 10;

endpackage

// File: rtl/pmod_clkgen.sv
// pck divider: DIV ACLK cycles per half-period, rises gated by hold/pwait.
module pmod_clkgen #(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    input  logic pwait,
    output logic pck,
    output logic rise,
    output logic fall
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pck_q, pck_d;
    logic          at_edge;

    always_comb begin
        at_edge = run && (cnt_q == LAST);
        rise    = at_edge && !pck_q && !hold && !pwait;
        fall    = at_edge && pck_q;
        cnt_d   = cnt_q + 1'b1;
        pck_d   = pck_q;
        if (!run) begin
            cnt_d = '0;
            pck_d = 1'b0;
        end else if (fall) begin
            cnt_d = '0;
            pck_d = 1'b0;
        end else if (rise) begin
            cnt_d = '0;
            pck_d = 1'b1;
        end else if (at_edge) begin
            // a stalled low phase parks at its final count, ready to rise
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pck_q <= pck_d;
        end
    end

    assign pck = pck_q;

endmodule

// File: rtl/pmod_host.sv
// PMOD host: serialises LEN/ADDR/DATA/GAP frames on a 2-bit bus, one slot per pck period.
module pmod_host
    import pmod_pkg::*;
#(
    parameter int DIV = 3,
    parameter int GAP = 12   // at least 1: the final read slot is sampled on the first GAP rise
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_len,
    input  logic [31:0] cmd_addr,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [7:0]  wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        pck,
    output logic        pwrite,
    output logic [1:0]  pwd,
    input  logic [1:0]  prd,
    input  logic        pwait
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [41:0]         hdr_q, hdr_d;
    logic [9:0]          len_q, len_d;
    logic                pwrite_q, pwrite_d;
    logic [1:0]          pwd_q, pwd_d;
    logic [7:0]          wbyte_q, wbyte_d;
    logic                rd_pend_q, rd_pend_d;
    logic [1:0]          rd_idx_q, rd_idx_d;
    logic                rd_lastslot_q, rd_lastslot_d;
    logic [7:0]          rd_buf_q, rd_buf_d;
    logic                rd_valid_q, rd_valid_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_last_q, rd_last_d;

    logic       run, hold, rise, fall;
    logic       need_byte, gap_full, last_data;
    logic [7:0] byte_src, rd_new;

    pmod_clkgen #(.DIV(DIV)) u_clkgen (
        .clk   (ACLK),
        .rst   (ARESET),
        .run   (run),
        .hold  (hold),
        .pwait (pwait),
        .pck   (pck),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        run       = (state_q != ST_IDLE);
        need_byte = (state_q == ST_DATA) && pwrite_q && (slot_q[1:0] == 2'b00);
        gap_full  = (state_q == ST_GAP) && (slot_q == SLOT_W'(GAP));
        last_data = (slot_q == len_q - 10'd1);
        hold      = gap_full || rd_valid_q || (need_byte && !wd_valid);
        byte_src  = need_byte ? wd_data : wbyte_q;
        rd_new    = ((rd_idx_q == 2'd0) ? 8'h00 : rd_buf_q) | (8'(prd) << {rd_idx_q, 1'b0});

        state_d       = state_q;
        slot_d        = slot_q;
        hdr_d         = hdr_q;
        len_d         = len_q;
        pwrite_d      = pwrite_q;
        pwd_d         = pwd_q;
        wbyte_d       = wbyte_q;
        rd_pend_d     = rd_pend_q;
        rd_idx_d      = rd_idx_q;
        rd_lastslot_d = rd_lastslot_q;
        rd_buf_d      = rd_buf_q;
        rd_valid_d    = rd_valid_q;
        rd_data_d     = rd_data_q;
        rd_last_d     = rd_last_q;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        if (state_q == ST_IDLE && cmd_valid) begin
            state_d  = ST_LEN;
            slot_d   = '0;
            hdr_d    = {cmd_addr, cmd_len};
            len_d    = cmd_len;
            pwrite_d = cmd_write;
        end else if (gap_full && fall) begin
            state_d = ST_IDLE;
            slot_d  = '0;
        end

        // every rise closes the previous slot (read sample) and opens the next one
        if (rise) begin
            if (rd_pend_q) begin
                rd_buf_d = rd_new;
                if (rd_idx_q == 2'(SLOTS_PER_BYTE - 1) || rd_lastslot_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_new;
                    rd_last_d  = rd_lastslot_q;
                end
            end
            rd_pend_d = 1'b0;
            slot_d    = slot_q + 1'b1;
            case (state_q)
                ST_LEN, ST_ADDR: begin
                    pwd_d = hdr_q[1:0];
                    hdr_d = hdr_q >> 2;
                    if (state_q == ST_LEN && slot_q == SLOT_W'(LEN_SLOTS - 1)) begin
                        state_d = ST_ADDR;
                        slot_d  = '0;
                    end else if (state_q == ST_ADDR && slot_q == SLOT_W'(ADDR_SLOTS - 1)) begin
                        state_d = (len_q == 10'd0) ? ST_GAP : ST_DATA;
                        slot_d  = '0;
                    end
                end
                ST_DATA: begin
                    if (pwrite_q) begin
                        pwd_d   = byte_src[1:0];
                        wbyte_d = byte_src >> 2;
                    end else begin
                        pwd_d         = 2'b00;
                        rd_pend_d     = 1'b1;
                        rd_idx_d      = slot_q[1:0];
                        rd_lastslot_d = last_data;
                    end
                    if (last_data) begin
                        state_d = ST_GAP;
                        slot_d  = '0;
                    end
                end
                default: pwd_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            pwrite_q      <= 1'b0;
            pwd_q         <= 2'b00;
            rd_pend_q     <= 1'b0;
            rd_idx_q      <= 2'd0;
            rd_lastslot_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            pwrite_q      <= pwrite_d;
            pwd_q         <= pwd_d;
            rd_pend_q     <= rd_pend_d;
            rd_idx_q      <= rd_idx_d;
            rd_lastslot_q <= rd_lastslot_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_last_q     <= rd_last_d;
        end
    end

    always_ff @(posedge ACLK) begin
        hdr_q    <= hdr_d;
        len_q    <= len_d;
        wbyte_q  <= wbyte_d;
        rd_buf_q <= rd_buf_d;
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wd_ready  = rise && need_byte;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign pwrite    = pwrite_q;
    assign pwd       = pwd_q;

endmodule

// File: tb/tb_pmod_host.sv
// Directed bench for pmod_host: frames logged per pck rise and compared to hand/model values.
module tb_pmod_host;

    localparam int DIV = 3;
    localparam int GAP = 12;
    localparam logic [127:0] FRAME_W68 = 128'h01A10180001004;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [9:0]  cmd_len = '0;
    logic [31:0] cmd_addr = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [7:0]  wd_data = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [7:0]  rd_data;
    logic        pck, pwrite, pwait = 1'b0;
    logic [1:0]  pwd, prd = 2'b00;

    int   n_checks = 0;
    int   n_errors = 0;
    int   rise_total = 0;
    int   wd_hs = 0;
    logic [1:0] slot_log [0:4095];
    logic       pwrite_log [0:4095];

    pmod_host #(.DIV(DIV), .GAP(GAP)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .pck(pck), .pwrite(pwrite), .pwd(pwd), .prd(prd), .pwait(pwait)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge pck) begin
        #1;
        slot_log[rise_total % 4096]   = pwd;
        pwrite_log[rise_total % 4096] = pwrite;
        rise_total = rise_total + 1;
    end

    always @(negedge ACLK) begin
        if (wd_valid && wd_ready) wd_hs = wd_hs + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k = 0;
        while (rise_total < n && k < 3000) begin
            tick();
            k++;
        end
        if (rise_total < n) check({tag, "_rise_timeout"}, 128'(rise_total), 128'(n));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!cmd_ready && k < 3000) begin
            tick();
            k++;
        end
        if (!cmd_ready) check({tag, "_idle_timeout"}, 128'(cmd_ready), 128'(1));
    endtask

    task automatic wait_rd_valid(input string tag);
        int k = 0;
        while (!rd_valid && k < 3000) begin
            tick();
            k++;
        end
        if (!rd_valid) check({tag, "_rdv_timeout"}, 128'(rd_valid), 128'(1));
    endtask

    function automatic logic [127:0] model_frame(input logic wr, input logic [9:0] len,
                                                 input logic [31:0] addr, input logic [31:0] data);
        logic [127:0] f = '0;
        int n = 0;
        for (int i = 0; i < 5; i++) begin f[2*n +: 2] = len[2*i +: 2]; n++; end
        for (int i = 0; i < 16; i++) begin f[2*n +: 2] = addr[2*i +: 2]; n++; end
        for (int j = 0; j < int'(len) && n < 64; j++) begin
            if (wr && j < 16) f[2*n +: 2] = data[2*j +: 2];
            n++;
        end
        return f;
    endfunction

    function automatic logic [127:0] log_frame(input int start, input int n);
        logic [127:0] f = '0;
        for (int i = 0; i < n && i < 64; i++) f[2*i +: 2] = slot_log[(start + i) % 4096];
        return f;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [127:0] exp, input int exp_n);
        check({tag, "_slots"}, 128'(rise_total - start), 128'(exp_n));
        check({tag, "_pwd"}, log_frame(start, rise_total - start), exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pck"}, 128'(pck), 128'(0));
        check({tag, "_pwrite"}, 128'(pwrite), 128'(0));
        check({tag, "_pwd"}, 128'(pwd), 128'(0));
        check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        check({tag, "_wd_ready"}, 128'(wd_ready), 128'(0));
        check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
        check({tag, "_rd_last"}, 128'(rd_last), 128'(0));
        check({tag, "_rd_data"}, 128'(rd_data), 128'(0));
    endtask

    task automatic send_cmd(input logic wr, input logic [9:0] len, input logic [31:0] addr, output int start);
        start     = rise_total;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_len   = len;
        cmd_addr  = addr;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 128'(cmd_ready), 128'(0));
    endtask

    task automatic do_write(input string tag, input logic [9:0] len, input logic [31:0] addr,
                            input logic [7:0] b, input int stall_slot, input int wd_hold,
                            input logic [127:0] exp, input int exp_n);
        int start;
        int hs0;
        int r0;
        logic [1:0] p0;
        hs0      = wd_hs;
        wd_data  = b;
        wd_valid = (wd_hold == 0);
        send_cmd(1'b1, len, addr, start);
        if (stall_slot >= 0) begin
            wait_rises(start + stall_slot, tag);
            pwait = 1'b1;
            r0    = rise_total;
            p0    = pwd;
            repeat (20) tick();
            check({tag, "_pwait_rises"}, 128'(rise_total), 128'(r0));
            check({tag, "_pwait_pwd"}, 128'(pwd), 128'(p0));
            pwait = 1'b0;
        end
        if (wd_hold > 0) begin
            wait_rises(start + 21, tag);
            repeat (wd_hold) tick();
            check({tag, "_wdhold_rises"}, 128'(rise_total), 128'(start + 21));
            check({tag, "_wdhold_pck"}, 128'(pck), 128'(0));
            wd_valid = 1'b1;
        end
        wait_idle(tag);
        wd_valid = 1'b0;
        check_frame(tag, start, exp, exp_n);
        check({tag, "_wd_hs"}, 128'(wd_hs - hs0), 128'(1));
        check({tag, "_pwrite"}, 128'(pwrite_log[start % 4096]), 128'(1));
    endtask

    initial begin : main
        int start;
        int r0;
        int hs0;
        string msg;
        logic [1:0] rtbl [0:5];
        rtbl = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
        msg  = "hello, world\r\n";

        repeat (2) tick();
        ARESET = 1'b0;
        check_reset("rst");

        do_write("w68", 10'd4, 32'h4060_0004, 8'h68, -1, 0, FRAME_W68, 37);

        for (int i = 0; i < msg.len(); i++)
            do_write($sformatf("hello%0d", i), 10'd4, 32'h4060_0004, msg[i], -1, 0,
                     model_frame(1'b1, 10'd4, 32'h4060_0004, {24'h0, msg[i]}), 37);

        do_write("stall", 10'd4, 32'h4060_0004, 8'h68, 8, 0, FRAME_W68, 37);
        do_write("wdhold", 10'd4, 32'h4060_0004, 8'h68, -1, 30, FRAME_W68, 37);

        send_cmd(1'b0, 10'd6, 32'h1234_5678, start);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_rises(start + 22 + k, "rd_prd");
                    prd = rtbl[k];
                end
            end
            begin
                wait_rd_valid("rd0");
                r0 = rise_total;
                repeat (30) tick();
                check("rd_hold_rises", 128'(rise_total), 128'(r0));
                check("rd_hold_valid", 128'(rd_valid), 128'(1));
                check("rd0_data", 128'(rd_data), 128'(8'h93));
                check("rd0_last", 128'(rd_last), 128'(0));
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
                check("rd0_taken", 128'(rd_valid), 128'(0));
                wait_rd_valid("rd1");
                check("rd1_data", 128'(rd_data), 128'(8'h0D));
                check("rd1_last", 128'(rd_last), 128'(1));
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
            end
        join
        wait_idle("rd");
        prd = 2'b00;
        check_frame("rd", start, model_frame(1'b0, 10'd6, 32'h1234_5678, 32'h0), 39);
        check("rd_pwrite", 128'(pwrite_log[start % 4096]), 128'(0));

        hs0 = wd_hs;
        send_cmd(1'b1, 10'd0, 32'hDEAD_BEEF, start);
        wait_idle("len0");
        check_frame("len0", start, model_frame(1'b1, 10'd0, 32'hDEAD_BEEF, 32'h0), 33);
        check("len0_wd_hs", 128'(wd_hs - hs0), 128'(0));

        wd_data  = 8'hA5;
        wd_valid = 1'b1;
        send_cmd(1'b1, 10'd8, 32'h0000_1000, start);
        wait_rises(start + 23, "arst");
        ARESET = 1'b1;
        tick();
        check_reset("arst");
        ARESET = 1'b0;
        hs0 = wd_hs;
        r0  = rise_total;
        repeat (40) tick();
        check("arst_rises", 128'(rise_total), 128'(r0));
        check("arst_wd_hs", 128'(wd_hs - hs0), 128'(0));
        check("arst_rd_valid", 128'(rd_valid), 128'(0));
        wd_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at rise_total %0d", rise_total);
        $fatal(1);
    end

endmodule

// File: doc/pmod_host.md
PMOD_HOST -- requirements
Module: pmod_host

Interface
REQ-001 Parameters SHALL be: DIV, default 3, ACLK cycles per pck half-period (min 1); GAP, default 12, idle pck periods between transactions.
REQ-002 Ports SHALL be, as name direction width meaning:
- ACLK  in  1  sole clock
- ARESET  in  1  reset; one clock; reset is synchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_len  in  10  number of 2-bit data slots
- cmd_addr  in  32  target address
- wd_valid  in  1  write byte offered
- wd_ready  out  1  write byte taken when both high
- wd_data  in  8  write byte, slot-order LSB first
- rd_valid  out  1  read byte available
- rd_ready  in  1  read byte taken when both high
- rd_data  out  8  read byte, slot-order LSB first
- rd_last  out  1  final byte of the read
- pck  out  1  PMOD clock
- pwrite  out  1  transaction direction
- pwd  out  2  host-to-device data
- prd  in  2  device-to-host data
- pwait  in  1  device stall request

Function
REQ-003 The FSM SHALL have states IDLE, LEN, ADDR, DATA, GAP; a "slot" SHALL be one pck period (2*DIV ACLK cycles).
REQ-004 IDLE: cmd_ready=1, pck=0; on handshake, latch write/len/addr, set pwrite=cmd_write, go LEN.
REQ-005 LEN SHALL last 5 slots driving cmd_len[2k+1:2k] on slot k; ADDR SHALL last 16 slots driving cmd_addr[2k+1:2k].
REQ-006 pwd SHALL change only in the ACLK cycle in which pck rises and SHALL be held for the full slot.
REQ-007 DATA SHALL last cmd_len slots; cmd_len=0 SHALL skip DATA and go directly to GAP.
REQ-008 Write DATA: at slots 0,4,8,... the host SHALL take one byte (wd_ready pulses one cycle) and drive byte bits [2j+1:2j] on slot j mod 4; bits beyond cmd_len in the last byte SHALL be discarded.
REQ-009 If wd_valid is low when a byte is needed, pck SHALL stay low (no rise) until wd_valid is high.
REQ-010 Read DATA: pwd=00; prd SHALL be sampled in the ACLK cycle before each pck rise following the slot, packed LSB first.
REQ-011 A read byte SHALL be presented after every 4th slot and after the last slot (partial byte zero-padded, rd_last=1); rd_valid SHALL hold until rd_ready.
REQ-012 While rd_valid=1 and unaccepted, no further pck rise SHALL occur.
REQ-013 While pwait=1 (sampled on ACLK), pck SHALL not rise; a high phase in progress SHALL complete; pwd SHALL stay unchanged.
REQ-014 GAP SHALL drive pwd=00, toggle pck for GAP slots, then return to IDLE; cmd_ready SHALL be 0 outside IDLE.
REQ-015 Transactions SHALL be strictly serial; a new command SHALL never preempt an active one.

Reset
REQ-016 ARESET SHALL force IDLE and, on the next edge: pck=0, pwrite=0, pwd=00, cmd_ready=1, wd_ready=0, rd_valid=0, rd_last=0, rd_data=0, all counters 0.
REQ-017 ARESET mid-transaction SHALL abandon it with no further wd_ready or rd_valid pulses.

Structure
REQ-018 pmod_pkg SHALL hold the state enum and constants LEN_SLOTS=5, ADDR_SLOTS=16, SLOTS_PER_BYTE=4.
REQ-019 The pck divider and stall gating SHALL be a sub-module pmod_clkgen, emitting one-cycle rise/fall strobes to the FSM.

Verification
REQ-020 Scenarios:
- Write len=4, addr=0x4060_0004, byte 0x68 -> pwd sequence 00,01,00,00,00 / address pairs LSB first / 00,10,10,01; then 12 idle slots.
- Write of 14 bytes "hello, world\r\n" back-to-back -> each transaction frame matches; one wd_ready per command.
- Read len=6, prd returning 11,00,01,10,01,11 -> rd_data 0x93 (rd_last=0), then 0x0D (rd_last=1).
- pwait high for 20 ACLK mid-ADDR, and rd_ready held low 30 cycles -> no pck rise during either; resumes without lost or repeated slots.
- wd_valid withheld at DATA slot 0 -> pck held low until wd_valid rises.
- ARESET asserted during DATA; len=0 command -> outputs return to reset values next edge; len=0 produces LEN+ADDR+GAP only.
